// File: rtl/pcie_mbox_bridge.sv
// +--------------------------------------------------------------------------------+
// | pcie_mbox_bridge: host<->timing-model mailbox bridge over PCIe-shared BRAMs     |
// | Rev 1.0                                                                          |
// +--------------------------------------------------------------------------------+
`default_nettype none

module pcie_mbox_bridge #(
  parameter int NTHREADS    = 64,
  parameter int DW          = 32,
  parameter int AW          = 11,
  parameter int WBASE       = 0,
  parameter int WFIFO_DEPTH = 8,
  parameter int WR_CYCLES   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_pcie_re,
  output logic [AW-1:0]               o_pcie_raddr,
  input  logic [DW-1:0]               i_pcie_rdata,
  output logic                        o_pcie_we,
  output logic [AW-1:0]               o_pcie_waddr,
  output logic [DW-1:0]               o_pcie_wdata,
  input  logic                        i_pcie_wr_busy,
  input  logic                        i_proc_busy,
  output logic                        o_tm2cpu_valid,
  output logic [$clog2(NTHREADS)-1:0] o_tm2cpu_tid,
  output logic [DW-2:0]               o_tm2cpu_data,
  input  logic                        i_cpu2tm_valid,
  input  logic                        i_cpu2tm_retired,
  input  logic [$clog2(NTHREADS)-1:0] i_cpu2tm_tid,
  input  logic [DW-2:0]               i_cpu2tm_data,
  output logic                        o_cpu2tm_ready
);

  localparam int TW  = $clog2(NTHREADS);
  localparam int PW  = DW - 1;
  localparam int FAW = $clog2(WFIFO_DEPTH);
  localparam int CW  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // ---------------- read side ----------------
  logic [TW-1:0]       r_rd_idx;
  logic [TW-1:0]       r_ret_tid;
  logic                r_ret_v;
  logic [NTHREADS-1:0] r_rd_ab;
  logic                w_rd_new;

  assign o_pcie_re    = ~i_proc_busy & ~rst;
  assign o_pcie_raddr = AW'(r_rd_idx);
  assign w_rd_new     = r_ret_v & ~i_proc_busy & (i_pcie_rdata[DW-1] != r_rd_ab[r_ret_tid]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_idx       <= '0;
      r_ret_tid      <= '0;
      r_ret_v        <= 1'b0;
      r_rd_ab        <= '0;
      o_tm2cpu_valid <= 1'b0;
      o_tm2cpu_tid   <= '0;
      o_tm2cpu_data  <= '0;
    end else begin
      if (o_pcie_re)
        r_rd_idx <= (r_rd_idx == TW'(NTHREADS - 1)) ? '0 : r_rd_idx + TW'(1);
      r_ret_v        <= o_pcie_re;
      r_ret_tid      <= r_rd_idx;
      o_tm2cpu_valid <= w_rd_new;
      // A word suppressed by proc_busy keeps its old toggle and is picked up next sweep.
      if (w_rd_new) begin
        o_tm2cpu_tid         <= r_ret_tid;
        o_tm2cpu_data        <= i_pcie_rdata[DW-2:0];
        r_rd_ab[r_ret_tid]   <= ~r_rd_ab[r_ret_tid];
      end
    end
  end

  // ---------------- write FIFO ----------------
  logic [TW+PW-1:0] r_mem [WFIFO_DEPTH];
  logic [FAW-1:0]   r_wptr;
  logic [FAW-1:0]   r_rptr;
  logic [FAW:0]     r_count;
  logic [1:0]       r_state;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [TW+PW-1:0] w_head;
  logic [TW-1:0]    w_head_tid;
  logic [PW-1:0]    w_head_pl;

  assign w_full         = (r_count == (FAW+1)'(WFIFO_DEPTH));
  assign o_cpu2tm_ready = ~w_full;
  assign w_push         = i_cpu2tm_valid & i_cpu2tm_retired & ~w_full;
  assign w_pop          = (r_state == ST_ISSUE);
  assign w_head         = r_mem[r_rptr];
  assign w_head_tid     = w_head[TW+PW-1:PW];
  assign w_head_pl      = w_head[PW-1:0];

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= {i_cpu2tm_tid, i_cpu2tm_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FAW'(1);
      if (w_pop)  r_rptr <= r_rptr + FAW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FAW+1)'(1);
        2'b01:   r_count <= r_count - (FAW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  logic [CW-1:0]       r_hold_cnt;
  logic [TW-1:0]       r_wtid;
  logic [NTHREADS-1:0] r_wr_ab;

  assign o_pcie_we = (r_state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_wtid       <= '0;
      r_wr_ab      <= '0;
      o_pcie_waddr <= '0;
      o_pcie_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Address/data latch here so they stay stable for the whole write.
          if ((r_count != '0) && !i_pcie_wr_busy) begin
            r_state      <= ST_ISSUE;
            r_wtid       <= w_head_tid;
            o_pcie_waddr <= AW'(WBASE) + AW'(w_head_tid);
            o_pcie_wdata <= {~r_wr_ab[w_head_tid], w_head_pl};
          end
        end
        ST_ISSUE: begin
          r_wr_ab[r_wtid] <= ~r_wr_ab[r_wtid];
          if (WR_CYCLES == 1) begin
            r_state <= ST_IDLE;
          end else begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= CW'(1);
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt != CW'(WR_CYCLES - 1))
            r_hold_cnt <= r_hold_cnt + CW'(1);
          else if (!i_pcie_wr_busy)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
